mdu_hilo: RTL and testbench



---
 rtl/mdu_hilo.sv | 157 +++++++++++++++
 tb/tb_mdu_hilo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers, driven from the GPR read ports.
// Optional MDU_TRACE_EN macro prints every HI/LO update with the PC of the issuing instruction.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;
  logic        issue_md, commit, write_hi, write_lo;

  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [31:0] calc_hi, calc_lo;
  logic        neg_q, neg_r;

  // Result is computed at issue; the busy window only models the latency.
  always_comb begin
    prod    = '0;
    a_mag   = rs_data;
    b_mag   = rt_data;
    q_mag   = '0;
    r_mag   = '0;
    neg_q   = 1'b0;
    neg_r   = 1'b0;
    quot    = '0;
    rem     = '0;
    calc_hi = '0;
    calc_lo = '0;
    if (op[0]) begin
      prod = {32'b0, rs_data} * {32'b0, rt_data};
    end else begin
      prod = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
      a_mag = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
      b_mag = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
      neg_q = rs_data[31] ^ rt_data[31];
      neg_r = rs_data[31];
    end
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = neg_q ? (~q_mag + 32'd1) : q_mag;
    rem  = neg_r ? (~r_mag + 32'd1) : r_mag;
    if (op[1]) begin
      calc_hi = rem;
      calc_lo = quot;
    end else begin
      calc_hi = prod[63:32];
      calc_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue_md   = 1'b0;
    commit     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              issue_md   = 1'b1;
              state_next = BUSY;
            end
            3'd4:    write_hi = 1'b1;
            3'd5:    write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (count == 5'd1) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Divide by zero still occupies the unit but leaves HI/LO untouched at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (issue_md) begin
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
        pend_wr <= !(op[1] && rt_data == '0);
        count   <= op[1] ? DIV_LOAD : MULT_LOAD;
      end else if (state == BUSY) begin
        count <= count - 5'd1;
      end
      if (commit && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (write_hi) hi <= rs_data;
      if (write_lo) lo <= rs_data;
    end
  end

  assign busy = (state == BUSY);

`ifdef MDU_TRACE_EN
  logic [31:0] trace_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_pc <= '0;
    end else begin
      if (issue_md) trace_pc <= pc;
      if (commit && pend_wr) begin
        $display("@%h: $hi <= %h", trace_pc, pend_hi);
        $display("@%h: $lo <= %h", trace_pc, pend_lo);
      end
      if (write_hi) $display("@%h: $hi <= %h", pc, rs_data);
      if (write_lo) $display("@%h: $lo <= %h", pc, rs_data);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed steps with a queue of expected HI/LO results
// pushed at issue and popped when busy drops.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, pc;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: signed divide truncates toward zero with remainder taking the dividend sign.
  function automatic logic [63:0] modelResult(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb;
    int     q, r;
    logic [63:0] res;
    res = prev;
    case (o)
      3'd0: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'(sa * sb);
      end
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'h0)
          res = prev;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          res = {32'h0, 32'h8000_0000};
        else begin
          q   = int'($signed(a)) / int'($signed(b));
          r   = int'($signed(a)) % int'($signed(b));
          res = {32'(r), 32'(q)};
        end
      end
      3'd3: res = (b == 32'h0) ? prev : {a % b, a / b};
      default: res = prev;
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p);
    logic [63:0] r;
    r       = modelResult(o, a, b, {model_hi, model_lo});
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    pc      = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o <= 3'd3) begin
      exp_q.push_back(r);
      if (!(o[1] && b == 32'h0)) begin
        model_hi = r[63:32];
        model_lo = r[31:0];
      end
    end else if (o == 3'd4) begin
      model_hi = a;
    end else if (o == 3'd5) begin
      model_lo = a;
    end
  endtask

  // Drives a strobe the DUT must ignore because an operation is in flight.
  task automatic pulseIgnored(input logic [2:0] o, input logic [31:0] a);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitCommit(input int n, input string tag);
    int cycles;
    logic [63:0] e;
    cycles = 0;
    e      = 'x;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_cycles"}, 64'(cycles), 64'(n));
    checkOutput({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checkOutput({tag, "_hi"}, {32'h0, hi}, {32'h0, e[63:32]});
    checkOutput({tag, "_lo"}, {32'h0, lo}, {32'h0, e[31:0]});
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = '0;
    rs_data = '0;
    rt_data = '0;
    pc      = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_busy", {63'h0, busy}, 64'h0);
    checkOutput("reset_hi", {32'h0, hi}, 64'h0);
    checkOutput("reset_lo", {32'h0, lo}, 64'h0);

    applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3, 32'h100);
    waitCommit(5, "mult_neg");

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h104);
    waitCommit(5, "multu_max");

    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h108);
    waitCommit(10, "div_neg");

    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h10C);
    waitCommit(10, "div_ovf");

    applyStimulus(3'd4, 32'h11, 32'h0, 32'h110);
    checkOutput("mthi_busy", {63'h0, busy}, 64'h0);
    checkOutput("mthi_hi", {32'h0, hi}, {32'h0, model_hi});
    applyStimulus(3'd5, 32'h22, 32'h0, 32'h114);
    checkOutput("mtlo_lo", {32'h0, lo}, {32'h0, model_lo});

    applyStimulus(3'd3, 32'd7, 32'd0, 32'h118);
    waitCommit(10, "divu_zero");

    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd1, 32'h11C);
    checkOutput("rsvd_busy", {63'h0, busy}, 64'h0);
    checkOutput("rsvd_hilo", {hi, lo}, {model_hi, model_lo});

    applyStimulus(3'd0, 32'd4, 32'd5, 32'h120);
    pulseIgnored(3'd5, 32'h99);
    checkOutput("busy_lo_stable", {32'h0, lo}, {32'h0, 32'h22});
    waitCommit(4, "mult_mtlo_ignored");

    for (int i = 0; i < 4; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'($urandom_range(1, 300)) : $urandom;
      applyStimulus(ro, ra, rb, 32'h200 + 32'(i * 4));
      waitCommit(ro[1] ? 10 : 5, $sformatf("rand%0d_op%0d", i, ro));
    end

    applyStimulus(3'd2, 32'd100, 32'd7, 32'h300);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    checkOutput("abort_busy", {63'h0, busy}, 64'h0);
    checkOutput("abort_hilo", {hi, lo}, 64'h0);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("abort_no_commit", {hi, lo}, 64'h0);
    checkOutput("abort_idle", {63'h0, busy}, 64'h0);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
